// File: rtl/host_cmd_uart_tx.sv
// Host-side UART command serializer: expands one accepted command into its 2-4 byte
// frame list on TX_LINE. Optional inter-byte idle gap compiled in with HOST_CMD_GAP_EN.
module host_cmd_uart_tx (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       CMD_VLD,
    input  logic [7:0] CMD_CODE,
    input  logic [7:0] ARG0,
    input  logic [7:0] ARG1,
    input  logic [7:0] ARG2,
    output logic       CMD_RDY,
    output logic       TX_LINE,
    output logic       BUSY,
    output logic       DONE,
    output logic       CMD_ERR,
    output logic [2:0] o_dbg_state
);

    // Handshake: a command is taken on a rising edge where CMD_VLD and CMD_RDY are both
    // high; CMD_RDY is high only in IDLE, so nothing on the inputs matters while busy.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
`ifdef HOST_CMD_GAP_EN
        ,
        S_GAP    = 3'd5
`endif
    } state_t;

    state_t     r_state;
    logic [7:0] r_bytes [4];
    logic [5:0] r_p;
    logic       r_par_en;
    logic       r_par_typ;
    logic [5:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic [1:0] r_byte_idx;
    logic [1:0] r_last_idx;
    logic       r_tx;
    logic       r_busy;
    logic       r_rdy;
    logic       r_done;
    logic       r_err;
`ifdef HOST_CMD_GAP_EN
    logic [6:0] r_gap_cnt;
    logic       w_gap_end;
`endif

    logic       w_legal;
    logic [1:0] w_last_idx;
    logic [5:0] w_p_clamped;
    logic [7:0] w_cur_byte;
    logic       w_bit_end;
    logic       w_parity;
    logic       w_last_byte;

    always_comb begin
        w_legal    = 1'b1;
        w_last_idx = 2'd1;
        case (CMD_CODE)
            8'hAA:   w_last_idx = 2'd2;
            8'hBB:   w_last_idx = 2'd1;
            8'hCC:   w_last_idx = 2'd3;
            8'hDD:   w_last_idx = 2'd1;
            default: w_legal    = 1'b0;
        endcase
    end

    assign w_p_clamped = (Prescale < 6'd4) ? 6'd4 : Prescale;
    assign w_cur_byte  = r_bytes[r_byte_idx];
    assign w_bit_end   = (r_cnt == (r_p - 6'd1));
    assign w_parity    = r_par_typ ? ~(^w_cur_byte) : (^w_cur_byte);
    assign w_last_byte = (r_byte_idx == r_last_idx);
`ifdef HOST_CMD_GAP_EN
    // Gap spans two bit periods, which can exceed the 6-bit bit counter.
    assign w_gap_end   = (r_gap_cnt == ({1'b0, r_p} + {1'b0, r_p} - 7'd1));
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_bytes[0] <= 8'h00;
            r_bytes[1] <= 8'h00;
            r_bytes[2] <= 8'h00;
            r_bytes[3] <= 8'h00;
            r_p        <= 6'd4;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_cnt      <= 6'd0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_last_idx <= 2'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_rdy      <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef HOST_CMD_GAP_EN
            r_gap_cnt  <= 7'd0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (CMD_VLD) begin
                        if (w_legal) begin
                            r_bytes[0] <= CMD_CODE;
                            r_bytes[1] <= ARG0;
                            r_bytes[2] <= ARG1;
                            r_bytes[3] <= ARG2;
                            r_p        <= w_p_clamped;
                            r_par_en   <= PAR_EN;
                            r_par_typ  <= PAR_TYP;
                            r_last_idx <= w_last_idx;
                            r_byte_idx <= 2'd0;
                            r_cnt      <= 6'd0;
                            r_tx       <= 1'b0;
                            r_busy     <= 1'b1;
                            r_rdy      <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= 6'd0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= 6'd0;
                        if (r_bit_idx == 3'd7) begin
                            if (r_par_en) begin
                                r_tx    <= w_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= 6'd0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= 6'd0;
                        if (w_last_byte) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef HOST_CMD_GAP_EN
                            r_tx      <= 1'b1;
                            r_gap_cnt <= 7'd0;
                            r_state   <= S_GAP;
`else
                            r_tx    <= 1'b0;
                            r_state <= S_START;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
`ifdef HOST_CMD_GAP_EN
                S_GAP: begin
                    if (w_gap_end) begin
                        r_gap_cnt <= 7'd0;
                        r_cnt     <= 6'd0;
                        r_tx      <= 1'b0;
                        r_state   <= S_START;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 7'd1;
                    end
                end
`endif
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CMD_RDY     = r_rdy;
    assign TX_LINE     = r_tx;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign CMD_ERR     = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_host_cmd_uart_tx.sv
// Bench for host_cmd_uart_tx: random and directed commands, a UART receiver monitor
// decoding TX_LINE against an expected-byte queue, and per-command latency checks.
module tb_host_cmd_uart_tx;

    localparam int W = 16;
`ifdef HOST_CMD_GAP_EN
    localparam int GAP_ON = 1;
`else
    localparam int GAP_ON = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       CMD_VLD;
    logic [7:0] CMD_CODE;
    logic [7:0] ARG0;
    logic [7:0] ARG1;
    logic [7:0] ARG2;
    logic       CMD_RDY;
    logic       TX_LINE;
    logic       BUSY;
    logic       DONE;
    logic       CMD_ERR;
    logic [2:0] dbg_state;

    // Expected byte entry: {P[5:0], parity_enabled, parity_bit, data[7:0]}
    logic [W-1:0] exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b1;

    host_cmd_uart_tx dut (
        .CLK        (CLK),
        .RST        (RST),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .CMD_VLD    (CMD_VLD),
        .CMD_CODE   (CMD_CODE),
        .ARG0       (ARG0),
        .ARG1       (ARG1),
        .ARG2       (ARG2),
        .CMD_RDY    (CMD_RDY),
        .TX_LINE    (TX_LINE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CMD_ERR    (CMD_ERR),
        .o_dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic par_of(input logic [7:0] b, input logic pe, input logic pt);
        int ones;
        ones = $countones(b);
        if (!pe) return 1'b0;
        return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    // Driver: presents one command, pushes its expected bytes, returns expected DONE latency.
    task automatic issue(input logic [7:0] code, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [5:0] presc, input logic pe,
                         input logic pt, input bit push, output int lat);
        int         p;
        int         n;
        logic [7:0] bl [4];
        logic [5:0] p6;
        p  = (presc < 4) ? 4 : int'(presc);
        p6 = p[5:0];
        bl[0] = code; bl[1] = a0; bl[2] = a1; bl[3] = a2;
        case (code)
            8'hAA:   n = 3;
            8'hBB:   n = 2;
            8'hCC:   n = 4;
            8'hDD:   n = 2;
            default: n = 0;
        endcase
        lat = (n == 0) ? 0 : n * p * (10 + int'(pe)) + GAP_ON * (n - 1) * 2 * p;
        if (push) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({p6, pe, par_of(bl[i], pe, pt), bl[i]});
        end
        CMD_CODE = code; ARG0 = a0; ARG1 = a1; ARG2 = a2;
        Prescale = presc; PAR_EN = pe; PAR_TYP = pt;
        CMD_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VLD  = 1'b0;
        CMD_CODE = 8'($urandom); ARG0 = 8'($urandom); ARG1 = 8'($urandom); ARG2 = 8'($urandom);
        Prescale = 6'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        if (n > 0) begin
            check("accept_busy", BUSY, 1'b1);
            check("accept_rdy", CMD_RDY, 1'b0);
            check("accept_start_bit", TX_LINE, 1'b0);
            check("accept_no_err", CMD_ERR, 1'b0);
        end else begin
            check("illegal_err", CMD_ERR, 1'b1);
            check("illegal_busy", BUSY, 1'b0);
            check("illegal_rdy", CMD_RDY, 1'b1);
            check("illegal_line", TX_LINE, 1'b1);
            @(posedge CLK);
            #1;
            check("illegal_err_pulse", CMD_ERR, 1'b0);
            check("illegal_line_after", TX_LINE, 1'b1);
        end
    endtask

    task automatic wait_done(input int lat);
        int cyc;
        bit busy_drop;
        cyc = 0;
        busy_drop = 1'b0;
        while (cyc < lat + 40) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (DONE) break;
            if (!BUSY) busy_drop = 1'b1;
        end
        check("done_latency", cyc, lat);
        check("busy_held", busy_drop, 1'b0);
        check("done_busy_low", BUSY, 1'b0);
        check("done_rdy_high", CMD_RDY, 1'b1);
        check("done_line_idle", TX_LINE, 1'b1);
    endtask

    // Monitor: UART receiver sampling mid-bit, compares each decoded byte to the queue.
    initial begin : monitor
        logic [W-1:0] e;
        logic [7:0]   d;
        logic         st;
        logic         par;
        logic         sp;
        int           p;
        forever begin
            @(negedge CLK);
            if (mon_en && RST === 1'b1 && TX_LINE === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    while (TX_LINE !== 1'b1) @(negedge CLK);
                end else begin
                    e = exp_q.pop_front();
                    p = int'(e[15:10]);
                    repeat (p / 2) @(negedge CLK);
                    st = TX_LINE;
                    for (int i = 0; i < 8; i++) begin
                        repeat (p) @(negedge CLK);
                        d[i] = TX_LINE;
                    end
                    par = 1'b0;
                    if (e[9]) begin
                        repeat (p) @(negedge CLK);
                        par = TX_LINE;
                    end
                    repeat (p) @(negedge CLK);
                    sp = TX_LINE;
                    check("frame_start", st, 1'b0);
                    check("frame_data", d, e[7:0]);
                    check("frame_parity", par, e[8]);
                    check("frame_stop", sp, 1'b1);
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        int         lat;
        bit         done_seen;
        logic [7:0] code;
        logic [7:0] legal [4];
        legal[0] = 8'hAA; legal[1] = 8'hBB; legal[2] = 8'hCC; legal[3] = 8'hDD;

        RST = 1'b0;
        CMD_VLD = 1'b0; CMD_CODE = 8'h00; ARG0 = 8'h00; ARG1 = 8'h00; ARG2 = 8'h00;
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #12;
        check("reset_rdy", CMD_RDY, 1'b1);
        check("reset_line", TX_LINE, 1'b1);
        check("reset_busy", BUSY, 1'b0);
        check("reset_done", DONE, 1'b0);
        check("reset_err", CMD_ERR, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        issue(8'hAA, 8'h05, 8'h3C, 8'h00, 6'd8, 1'b0, 1'b0, 1'b1, lat);
        wait_done(lat);
        issue(8'hCC, 8'h12, 8'h34, 8'h01, 6'd16, 1'b1, 1'b0, 1'b1, lat);
        wait_done(lat);
        issue(8'hDD, 8'h00, 8'h00, 8'h00, 6'd2, 1'b1, 1'b1, 1'b1, lat);
        wait_done(lat);
        issue(8'h7E, 8'h11, 8'h22, 8'h33, 6'd8, 1'b0, 1'b0, 1'b1, lat);
        issue(8'hBB, 8'h02, 8'h00, 8'h00, 6'd8, 1'b0, 1'b0, 1'b1, lat);
        wait_done(lat);

        // Reset in the middle of bit 1 of the second byte (0x05)
        mon_en = 1'b0;
        issue(8'hAA, 8'h05, 8'h3C, 8'h00, 6'd8, 1'b0, 1'b0, 1'b0, lat);
        repeat (99) @(posedge CLK);
        #3;
        check("pre_reset_line", TX_LINE, 1'b0);
        RST = 1'b0;
        #1;
        check("async_reset_line", TX_LINE, 1'b1);
        check("async_reset_busy", BUSY, 1'b0);
        check("async_reset_rdy", CMD_RDY, 1'b1);
        done_seen = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE) done_seen = 1'b1;
        end
        RST = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (DONE) done_seen = 1'b1;
        end
        check("reset_no_done", done_seen, 1'b0);
        check("reset_idle_line", TX_LINE, 1'b1);
        mon_en = 1'b1;
        @(posedge CLK);
        #1;

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                code = 8'($urandom);
                while (code == 8'hAA || code == 8'hBB || code == 8'hCC || code == 8'hDD)
                    code = 8'($urandom);
            end else begin
                code = legal[$urandom_range(0, 3)];
            end
            issue(code, 8'($urandom), 8'($urandom), 8'($urandom),
                  6'($urandom_range(0, 20)), 1'($urandom), 1'($urandom), 1'b1, lat);
            if (lat > 0) wait_done(lat);
        end

        repeat (20) @(negedge CLK);
        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
